// File: rtl/screen_sequencer.sv
// Connect-4 display sequencer: picks board / winner frame, latches the winner and sequences restarts.
// Optional WINNER_BLINK_EN macro makes the winner screen blink against BG_COLOR.
module screen_sequencer #(
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned WIN_MIN_FRAMES = 30,
  parameter int unsigned BLINK_FRAMES   = 15,
  parameter logic [23:0] BG_COLOR       = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        game_over,
  input  logic [2:0]  winner,
  input  logic        restart,
  input  logic [23:0] board_rgb,
  input  logic [23:0] winner_rgb,
  output logic [23:0] rgb_color,
  output logic [2:0]  player_sel,
  output logic        game_over_ack,
  output logic        clear_board,
  output logic [1:0]  screen_state
);

  typedef enum logic [1:0] {S_PLAY = 2'b00, S_FREEZE = 2'b01, S_WIN = 2'b10, S_RESTART = 2'b11} state_t;
  typedef enum logic [1:0] {SRC_BOARD = 2'b00, SRC_WINNER = 2'b01, SRC_BG = 2'b10} src_t;

  state_t      state, state_nx;
  src_t        src_sel, src_nx;
  logic        at_origin, at_origin_q, frame_tick;
  logic        restart_q, restart_rise;
  logic [7:0]  frame_cnt;
  logic        ack_set, clr_set;
  logic [23:0] pix;

  assign at_origin    = (x == 10'd0) && (y == 10'd0);
  assign frame_tick   = at_origin && !at_origin_q;
  assign restart_rise = restart && !restart_q;
  assign screen_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      at_origin_q <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      at_origin_q <= at_origin;
      restart_q   <= restart;
    end
  end

`ifdef WINNER_BLINK_EN
  logic       blink_on;
  logic [7:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_on  <= 1'b1;
      blink_cnt <= 8'd0;
    end else if (state_nx == S_WIN && state != S_WIN) begin
      blink_on  <= 1'b1;
      blink_cnt <= 8'd0;
    end else if (state == S_WIN && frame_tick) begin
      if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt <= 8'd0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_PLAY;
    else     state <= state_nx;
  end

  // game_over is tested first so it wins over a same-cycle restart edge
  always_comb begin
    state_nx = state;
    unique case (state)
      S_PLAY:    if (game_over) state_nx = S_FREEZE;
                 else if (restart_rise) state_nx = S_RESTART;
      S_FREEZE:  if (frame_tick && frame_cnt == 8'(HOLD_FRAMES - 1)) state_nx = S_WIN;
      S_WIN:     if (restart_rise && frame_cnt >= 8'(WIN_MIN_FRAMES)) state_nx = S_RESTART;
      S_RESTART: if (frame_tick) state_nx = S_PLAY;
    endcase
  end

  always_comb begin
    ack_set = (state == S_PLAY) && game_over;
    clr_set = (state != S_RESTART) && (state_nx == S_RESTART);
    src_nx  = SRC_BOARD;
    if (state == S_WIN) begin
`ifdef WINNER_BLINK_EN
      src_nx = blink_on ? SRC_WINNER : SRC_BG;
`else
      src_nx = SRC_WINNER;
`endif
    end
  end

  always_comb begin
    unique case (src_sel)
      SRC_WINNER: pix = winner_rgb;
      SRC_BG:     pix = BG_COLOR;
      default:    pix = board_rgb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt     <= 8'd0;
      src_sel       <= SRC_BOARD;
      rgb_color     <= 24'hFFFFFF;
      player_sel    <= 3'b000;
      game_over_ack <= 1'b0;
      clear_board   <= 1'b0;
    end else begin
      if (state_nx != state)                   frame_cnt <= 8'd0;
      else if (frame_tick && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
      // source only switches on a frame boundary so a frame is never torn
      if (frame_tick) src_sel <= src_nx;
      rgb_color     <= pix;
      game_over_ack <= ack_set;
      clear_board   <= clr_set;
      if (ack_set)      player_sel <= (winner == 3'd1 || winner == 3'd2) ? winner : 3'b000;
      else if (clr_set) player_sel <= 3'b000;
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: frame-level reference model plus directed literal checks.
module tb_screen_sequencer;
  localparam int          HOLD  = 60;
  localparam int          WMIN  = 30;
  localparam int          BLINK = 15;
  localparam logic [23:0] BG    = 24'hFFFFFF;
  localparam logic [23:0] WRGB  = 24'hED1B24;
  localparam int          FLEN  = 8;
`ifdef WINNER_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, game_over, restart;
  logic [9:0]  x, y;
  logic [2:0]  winner;
  logic [23:0] board_rgb, winner_rgb;
  logic [23:0] rgb_color;
  logic [2:0]  player_sel;
  logic        game_over_ack, clear_board;
  logic [1:0]  screen_state;

  int checks = 0, errors = 0;
  int ack_cnt = 0, clr_cnt = 0;
  bit chk_en = 1'b0;

  screen_sequencer #(.HOLD_FRAMES(HOLD), .WIN_MIN_FRAMES(WMIN), .BLINK_FRAMES(BLINK), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .game_over(game_over), .winner(winner),
    .restart(restart), .board_rgb(board_rgb), .winner_rgb(winner_rgb),
    .rgb_color(rgb_color), .player_sel(player_sel), .game_over_ack(game_over_ack),
    .clear_board(clear_board), .screen_state(screen_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: states 0 PLAY, 1 FREEZE, 2 WIN, 3 RESTART; sources 0 board, 1 winner, 2 bg
  int          m_state, m_ticks, m_src, m_ns, m_cnt;
  bit          m_prev_org, m_prev_rs, m_tick, m_rise;
  logic [23:0] m_rgb;
  logic [2:0]  m_ps;
  bit          m_ack, m_clr;

  function automatic int shown_for(input int st, input int ticks);
    if (st != 2) return 0;
    if (BLINK_ON && ((ticks / BLINK) % 2) == 1) return 2;
    return 1;
  endfunction

  function automatic logic [23:0] color_of(input int s, input logic [23:0] b, input logic [23:0] w);
    return (s == 1) ? w : (s == 2) ? BG : b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_ticks = 0; m_src = 0; m_prev_org = 0; m_prev_rs = 0;
      m_rgb = 24'hFFFFFF; m_ps = 3'b000; m_ack = 0; m_clr = 0;
    end else begin
      m_tick = (x == 10'd0 && y == 10'd0) && !m_prev_org;
      m_rise = restart && !m_prev_rs;
      m_cnt  = (m_ticks > 255) ? 255 : m_ticks;
      m_rgb  = color_of(m_src, board_rgb, winner_rgb);
      m_ns = m_state; m_ack = 0; m_clr = 0;
      if (m_state == 0 && game_over) begin
        m_ns = 1; m_ack = 1;
        m_ps = (winner == 3'd1 || winner == 3'd2) ? winner : 3'b000;
      end else if (m_state == 0 && m_rise) m_ns = 3;
      else if (m_state == 1 && m_tick && m_cnt == HOLD - 1) m_ns = 2;
      else if (m_state == 2 && m_rise && m_cnt >= WMIN) m_ns = 3;
      else if (m_state == 3 && m_tick) m_ns = 0;
      if (m_ns == 3 && m_state != 3) begin m_clr = 1; m_ps = 3'b000; end
      if (m_tick) m_src = shown_for(m_state, m_ticks);
      if (m_ns != m_state) begin m_state = m_ns; m_ticks = 0; end
      else if (m_tick) m_ticks++;
      m_prev_org = (x == 10'd0 && y == 10'd0);
      m_prev_rs  = restart;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rgb_color",     rgb_color,     m_rgb);
      check("player_sel",    player_sel,    m_ps);
      check("game_over_ack", game_over_ack, m_ack);
      check("clear_board",   clear_board,   m_clr);
      check("screen_state",  screen_state,  m_state[1:0]);
      if (game_over_ack === 1'b1) ack_cnt++;
      if (clear_board === 1'b1)   clr_cnt++;
    end
  end

  task automatic step(input logic [9:0] nx, input logic [9:0] ny);
    x = nx; y = ny;
    @(posedge clk); #1;
    if (game_over_ack === 1'b1) game_over = 1'b0;
    board_rgb = board_rgb + 24'h010203;
  endtask

  task automatic frame(input int org);
    for (int i = 0; i < org; i++) step(10'd0, 10'd0);
    for (int i = org; i < FLEN; i++) step(10'(i + 1), 10'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1; x = 10'd5; y = 10'd5; game_over = 0; winner = 3'b000; restart = 0;
    board_rgb = 24'h100000; winner_rgb = WRGB;
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1;
    check("reset state", screen_state, 2'b00);
    check("reset rgb",   rgb_color,    24'hFFFFFF);
    check("reset psel",  player_sel,   3'b000);
    check("reset ack",   game_over_ack, 1'b0);
    check("reset clr",   clear_board,  1'b0);
    rst = 0;
    frame(1); frame(1);

    game_over = 1; winner = 3'b010;
    step(10'd5, 10'd5); step(10'd6, 10'd5);
    check("go state", screen_state, 2'b01);
    check("go psel",  player_sel,   3'b010);
    check("go ackcnt", ack_cnt,     1);

    // held (0,0) must still count once per frame
    for (int f = 1; f <= HOLD - 1; f++) frame((f % 10 == 0) ? 4 : 1);
    check("hold still freeze", screen_state, 2'b01);
    frame(1);
    check("enter win", screen_state, 2'b10);
    frame(1);
    check("winner shown", rgb_color, WRGB);

    repeat (9) frame(1);
    restart = 1; step(10'd3, 10'd3);
    check("early restart dropped", screen_state, 2'b10);
    repeat (10) frame(1);
    check("blink phase frame20", rgb_color, BLINK_ON ? BG : WRGB);
    repeat (10) frame(1);
    check("held restart not queued", screen_state, 2'b10);
    restart = 0; step(10'd3, 10'd3);
    restart = 1; step(10'd3, 10'd3); step(10'd4, 10'd3);
    check("restart state", screen_state, 2'b11);
    check("restart psel",  player_sel,   3'b000);
    check("restart clrcnt", clr_cnt,     1);
    frame(1);
    check("back to play", screen_state, 2'b00);

    restart = 0; step(10'd3, 10'd3);
    game_over = 1; winner = 3'b111; restart = 1;
    step(10'd3, 10'd3); step(10'd4, 10'd3);
    check("tie state",  screen_state, 2'b01);
    check("tie ackcnt", ack_cnt,      2);
    check("tie clrcnt", clr_cnt,      1);
    check("draw psel",  player_sel,   3'b000);
    restart = 0;

    rst = 1; game_over = 1; winner = 3'b001;
    step(10'd3, 10'd3); step(10'd4, 10'd3);
    check("midrst state",  screen_state, 2'b00);
    check("midrst rgb",    rgb_color,    24'hFFFFFF);
    check("midrst ackcnt", ack_cnt,      2);
    check("midrst psel",   player_sel,   3'b000);
    rst = 0;
    step(10'd3, 10'd3); step(10'd4, 10'd3);
    check("post rst psel",  player_sel, 3'b001);
    check("post rst ackcnt", ack_cnt,   3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
